// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request latch and its priority encoder.
package irq_pkg;

  localparam int N_SRC = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // One-hot mask selecting the pending bit that belongs to a source ID.
  function automatic logic [N_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    id_onehot     = '0;
    id_onehot[id] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_prio_enc8.sv
// Combinational 8-to-3 priority encoder: the highest set index wins.
module irq_prio_enc8
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic [ID_W-1:0]  id,
  output logic             found
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i]) begin
        id    = ID_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_request_latch.sv
// Edge-captures 8 request lines into pending bits, arbitrates the highest
// unmasked one and presents its ID on a valid/ack handshake.
module irq_request_latch
  import irq_pkg::*;
#(
  parameter int N_SRC   = irq_pkg::N_SRC,
  parameter int ID_W    = irq_pkg::ID_W,
  parameter int SYNC_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic [N_SRC-1:0] mask,
  input  logic             irq_ack,
  input  logic             ovr_clr,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun
);

  logic [N_SRC-1:0] samp;
  logic [N_SRC-1:0] prev_p2;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] ovr_evt;
  logic [N_SRC-1:0] pending_n;
  logic [N_SRC-1:0] overrun_n;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  enc_id;
  logic [ID_W-1:0]  id_n;
  logic             enc_found;
  state_t           state;
  state_t           state_n;

  // ---- stage p0/p1: optional synchronizer ----
  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [N_SRC-1:0] src_p0;
      logic [N_SRC-1:0] src_p1;

      // Two-flop synchronizer for the raw asynchronous request lines.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          src_p0 <= '0;
          src_p1 <= '0;
        end else begin
          src_p0 <= src_in;
          src_p1 <= src_p0;
        end
      end

      assign samp = src_p1;
    end else begin : g_nosync
      assign samp = src_in;
    end
  endgenerate

  // ---- stage p2: edge detect and pending/overrun update ----
  // Previous sample resets to 0, so a line already high at reset release
  // is seen as a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_p2 <= '0;
    else     prev_p2 <= samp;
  end

  assign rise      = samp & ~prev_p2;
  assign ack_clr   = (state == WAIT && irq_ack) ? id_onehot(irq_id) : '0;
  // A bit being cleared by ack this cycle frees its slot: no overrun.
  assign ovr_evt   = rise & pending & ~ack_clr;
  // Set beats clear when both hit the same bit.
  assign pending_n = rise | (pending & ~ack_clr);
  // New overrun events survive a simultaneous ovr_clr.
  assign overrun_n = ovr_evt | (ovr_clr ? '0 : overrun);
  assign eligible  = pending & ~mask;

  // Pending and sticky overrun registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= pending_n;
      overrun <= overrun_n;
    end
  end

  irq_prio_enc8 u_enc (
    .req   (eligible),
    .id    (enc_id),
    .found (enc_found)
  );

  // ---- handshake FSM ----
  // State and the held grant ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state  <= state_n;
      irq_id <= id_n;
    end
  end

  // Grant only from IDLE; in WAIT the ID is frozen until acknowledged.
  always_comb begin
    state_n = state;
    id_n    = irq_id;
    case (state)
      IDLE: begin
        if (enc_found) begin
          state_n = WAIT;
          id_n    = enc_id;
        end
      end
      WAIT: begin
        if (irq_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign irq_valid = (state == WAIT);

endmodule

// File: tb/tb_irq_request_latch.sv
// Randomized bench for irq_request_latch with a rule-level reference model
// feeding a scoreboard that a separate monitor drains.
module tb_irq_request_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       ovr_clr;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] overrun;

  irq_request_latch #(.N_SRC(8), .ID_W(3), .SYNC_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_in    (src_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .ovr_clr   (ovr_clr),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       v;
    bit [2:0] id;
    bit [7:0] p;
    bit [7:0] o;
  } snap_t;

  snap_t    exp_q[$];
  bit [2:0] grant_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: history of sampled lines (newest first), pending and
  // overrun sets, and the current grant.
  bit [7:0] h1, h2, h3;
  bit [7:0] m_pend, m_ovr, old_pend;
  bit       m_valid;
  bit [2:0] m_id;
  int       clr_idx, best;

  always @(posedge clk) begin
    if (rst) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_pend = 0; m_ovr = 0; m_valid = 0; m_id = 0;
    end else begin
      old_pend = m_pend;
      clr_idx  = (m_valid && irq_ack) ? int'(m_id) : -1;
      if (ovr_clr) m_ovr = 0;
      for (int i = 0; i < 8; i++) begin
        if (h2[i] && !h3[i]) begin
          if (old_pend[i] && clr_idx != i) m_ovr[i] = 1;
          m_pend[i] = 1;
        end else if (clr_idx == i) begin
          m_pend[i] = 0;
        end
      end
      if (!m_valid) begin
        best = -1;
        for (int i = 0; i < 8; i++)
          if (old_pend[i] && !mask[i]) best = i;
        if (best >= 0) begin
          m_valid = 1;
          m_id    = 3'(best);
          grant_q.push_back(m_id);
        end
      end else if (irq_ack) begin
        m_valid = 0;
      end
      h3 = h2; h2 = h1; h1 = src_in;
    end
    exp_q.push_back('{v: m_valid, id: m_id, p: m_pend, o: m_ovr});
  end

  // Monitor: compares DUT outputs against the scoreboard every cycle and
  // checks each new grant against the expected grant order.
  snap_t e;
  bit    have_e;
  bit    prev_valid = 0;

  always @(negedge clk) begin
    have_e = 0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      have_e = 1;
    end
    if (rst) begin
      chk("rst_valid",   32'(irq_valid), 32'd0);
      chk("rst_id",      32'(irq_id),    32'd0);
      chk("rst_pending", 32'(pending),   32'd0);
      chk("rst_overrun", 32'(overrun),   32'd0);
      grant_q.delete();
      prev_valid = 0;
    end else if (have_e) begin
      chk("valid",   32'(irq_valid), 32'(e.v));
      chk("irq_id",  32'(irq_id),    32'(e.id));
      chk("pending", 32'(pending),   32'(e.p));
      chk("overrun", 32'(overrun),   32'(e.o));
      if (irq_valid && !prev_valid) begin
        if (grant_q.size() == 0) chk("grant_unexpected", 32'(irq_id), 32'hFFFF_FFFF);
        else                     chk("grant_order", 32'(irq_id), 32'(grant_q.pop_front()));
      end
      prev_valid = irq_valid;
    end
  end

  task automatic step(input bit [7:0] s, input bit [7:0] m, input bit a, input bit o);
    @(posedge clk); #1;
    src_in = s; mask = m; irq_ack = a; ovr_clr = o;
  endtask

  // Acknowledge every grant as soon as it appears.
  task automatic serve(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      irq_ack = irq_valid;
    end
    irq_ack = 0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; src_in = 0; mask = 0; irq_ack = 0; ovr_clr = 0;
    wait_cycles(3);
    rst = 0;

    // Single source pulse, then service.
    step(8'h01, 8'h00, 0, 0);
    wait_cycles(2);
    src_in = 8'h00;
    wait_cycles(3);
    serve(4);

    // Four simultaneous sources served highest first.
    step(8'h95, 8'h00, 0, 0);
    serve(14);
    step(8'h00, 8'h00, 0, 0);
    wait_cycles(2);

    // Masked source 7 held back until the mask lifts.
    step(8'h90, 8'h80, 0, 0);
    serve(10);
    mask = 8'h00;
    serve(6);
    step(8'h00, 8'h00, 0, 0);
    wait_cycles(2);

    // No preemption: source 6 arrives while 2 is granted.
    step(8'h04, 8'h00, 0, 0);
    wait_cycles(5);
    src_in = 8'h44;
    wait_cycles(6);
    serve(8);
    step(8'h00, 8'h00, 0, 0);
    wait_cycles(2);

    // Overrun on source 3, then clear it.
    step(8'h08, 8'h08, 0, 0);
    wait_cycles(2);
    src_in = 8'h00;
    wait_cycles(2);
    src_in = 8'h08;
    wait_cycles(4);
    ovr_clr = 1;
    wait_cycles(1);
    ovr_clr = 0;
    src_in = 8'h00;
    mask = 8'h00;
    serve(6);

    // Reset mid-handshake with a line held high through release.
    step(8'h01, 8'h00, 0, 0);
    wait_cycles(6);
    rst = 1;
    wait_cycles(2);
    rst = 0;
    serve(8);
    step(8'h00, 8'h00, 0, 0);
    wait_cycles(2);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      src_in  = src_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(15) == 0) mask = 8'($urandom) & 8'($urandom);
      irq_ack = ($urandom_range(2) != 0);
      ovr_clr = ($urandom_range(11) == 0);
      if ($urandom_range(399) == 0) begin
        rst = 1;
        wait_cycles(2);
        rst = 0;
      end
    end

    // Drain everything still pending.
    step(8'h00, 8'h00, 0, 0);
    serve(40);
    wait_cycles(2);
    @(negedge clk); #1;
    chk("grants_drained", 32'(grant_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Upstream front end for the 8-to-3 priority encoder stage.
- Turns 8 asynchronous request lines into edge-captured pending bits and applies a mask.
- Selects the highest-index eligible request and presents its 3-bit ID on a valid/ack handshake.
- Clears the serviced pending bit on acknowledge and flags requests lost to overrun.

Parameters:
- N_SRC, 8, number of request sources; fixed at 8 for this revision.
- ID_W, 3, width of irq_id; equals clog2(N_SRC).
- SYNC_EN, 1, 1 = two-flop synchronizer on src_in; 0 = src_in is already synchronous to clk.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- src_in  input  8  raw request lines, rising-edge sensitive.
- mask  input  8  1 = source disabled for selection; its pending bit is still captured.
- irq_ack  input  1  consumer accepts the current irq_id.
- ovr_clr  input  1  clears all overrun bits.
- irq_valid  output  1  irq_id is valid and held.
- irq_id  output  3  index of the selected source.
- pending  output  8  captured, unserviced requests.
- overrun  output  8  sticky flag: an edge arrived while that source's pending bit was already set.

Behaviour:
- Reset (async, rst=1): all outputs are 0; synchronizer flops, previous-sample register and FSM return to IDLE.
  - Because the previous sample resets to 0, a source already high when rst deasserts is captured as an edge.
  - rst asserted mid-handshake drops irq_valid immediately; the in-flight request is lost.
- Synchronizer (SYNC_EN=1): s1 <= src_in, s2 <= s1.
  - Edge detect: rise = s2 & ~prev; prev <= s2.
  - Timing: src_in first sampled high at edge E0 -> pending bit set at E2.
  - SYNC_EN=0: rise = src_in & ~prev; pending bit set at E0.
- Pending update, per bit, each cycle:
  - set if rise[i];
  - else cleared if the ack clear applies to i;
  - a set and a clear of the same bit in the same cycle: set wins, no overrun.
  - rise[i] with pending[i] already 1 and no clear that cycle: overrun[i] <= 1.
- Overrun clearing: ovr_clr clears all overrun bits. If a new overrun event coincides with ovr_clr, the new event wins.
- eligible = pending & ~mask.
- Priority: highest set index of eligible wins (eligible 8'b10010101 -> 3'b111).
- FSM, 2 states:
  - IDLE: irq_valid=0. If eligible != 0: irq_id <= encode(eligible), irq_valid <= 1, go to WAIT. irq_ack is ignored in IDLE.
  - WAIT: irq_valid=1; irq_id is held stable. No preemption by a higher-priority arrival, and no withdrawal if mask later covers irq_id.
  - On irq_ack in WAIT: clear pending[irq_id], irq_valid <= 0, go to IDLE.
- Latency and throughput:
  - pending set at edge E -> irq_valid=1 after edge E+1.
  - Minimum service rate: one request per 2 cycles (ack cycle, then IDLE re-arbitration cycle using the updated pending).
- irq_id reset value is 0. irq_id holds its last value while in IDLE; the consumer must qualify it with irq_valid.
- Widths: all vectors are N_SRC wide; no arithmetic beyond the encode.

Decomposition:
- Shared package irq_pkg holds:
  - N_SRC, ID_W;
  - state encoding IDLE=1'b0, WAIT=1'b1.
- One natural sub-module: irq_prio_enc8.
  - Combinational 8-to-3 highest-index priority encoder with a `found` output (found=0 when input is 0).
  - Used for the IDLE selection; the FSM advances only when found=1.

Test Plan:
1. Reset, SYNC_EN=1, then pulse src_in=8'b00000001 for 3 cycles -> pending=8'h01 two edges after first sample; irq_valid=1, irq_id=0 one edge later; irq_ack -> pending=0, irq_valid=0.
2. Simultaneous src_in 8'h00->8'b10010101, mask=0 -> ids serviced in order 7,4,2,0 with ack each time; pending sequence 8'h95, 8'h15, 8'h05, 8'h01, 8'h00.
3. mask=8'h80, rises on 7 and 4 -> irq_id=4 served; pending stays 8'h80 and no irq_valid until mask=0, then irq_id=7.
4. In WAIT with irq_id=2, rise on 6 -> irq_id stays 2 until ack; next grant is 6.
5. Second rise on source 3 while pending[3]=1 -> overrun=8'h08; ovr_clr -> 8'h00. Rise on 3 in the same cycle as its ack -> pending[3] stays 1, overrun stays 0.
6. Assert rst while irq_valid=1 -> outputs 0 immediately. Hold src_in=8'h01 high through reset release -> captured as a new edge, irq_id=0 granted.
